multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
// - Sequencing controller for the multicycle variant of the RISC-V core: one shared ALU and one unified memory reused across cycles.
// - Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB and drives datapath enables and mux selects.
// - Handshakes with a memory that may insert wait states, and times out hung accesses.
// - Supports R-type, I-type ALU, load (lw), store (sw) and beq; all other opcodes are illegal.
// PARAMETERS
// - WAIT_TIMEOUT  16  max cycles a memory access may wait for mem_ready before bus_error
// - TMR_W          5  width of the wait counter; must satisfy 2**TMR_W > WAIT_TIMEOUT
// PORTS
// - clk           in   1  rising-edge clock
// - rst_n         in   1  asynchronous active-low reset
// - opcode        in   7  instruction[6:0] from the instruction register
// - zero          in   1  ALU zero flag
// - mem_ready     in   1  memory access complete this cycle
// - mem_read      out  1  memory read request, held until accepted
// - mem_write     out  1  memory write request, held until accepted
// - adr_src       out  1  memory address: 0 = PC, 1 = ALU result register
// - ir_write      out  1  load instruction register and old-PC register
// - pc_write      out  1  PC update strobe
// - reg_write     out  1  register-file write strobe
// - alu_src_a     out  2  00 = PC, 01 = old PC, 10 = rs1
// - alu_src_b     out  2  00 = rs2, 01 = immediate, 10 = constant 4
// - alu_op        out  2  00 = add, 01 = sub, 10 = decode funct3/funct7
// - result_src    out  2  00 = ALU result reg, 01 = memory data reg, 10 = ALU out
// - illegal_op    out  1  one-cycle pulse on an unsupported opcode
// - bus_error     out  1  one-cycle pulse when a memory wait times out
// - busy          out  1  high in every state except IDLE
// BEHAVIOUR
// - Reset: state = IDLE, wait counter = 0, all outputs 0. IDLE -> FETCH unconditionally on the next edge.
// - Outputs are decoded combinationally from the state (Moore), with two exceptions:
//   - pc_write in FETCH = mem_ready.
//   - pc_write in BRANCH = zero.
// - Any output not listed for a state is 0.
// - States and transitions:
//   - FETCH:   mem_read=1, adr_src=0, ir_write=mem_ready, alu_src_a=00, alu_src_b=10, alu_op=00.
//              Stays while !mem_ready; -> DECODE when mem_ready.
//   - DECODE:  alu_src_a=01, alu_src_b=01, alu_op=00 (branch target precompute).
//              lw/sw -> MEM_ADR; R -> EXEC_R; I -> EXEC_I; beq -> BRANCH.
//              Any other opcode: pulse illegal_op, -> FETCH.
//   - MEM_ADR: alu_src_a=10, alu_src_b=01, alu_op=00. lw -> MEM_RD; sw -> MEM_WR.
//   - MEM_RD:  mem_read=1, adr_src=1. -> MEM_WB on mem_ready.
//   - MEM_WR:  mem_write=1, adr_src=1. -> FETCH on mem_ready.
//   - MEM_WB:  reg_write=1, result_src=01. -> FETCH.
//   - EXEC_R:  alu_src_a=10, alu_src_b=00, alu_op=10. -> ALU_WB.
//   - EXEC_I:  alu_src_a=10, alu_src_b=01, alu_op=10. -> ALU_WB.
//   - ALU_WB:  reg_write=1, result_src=00. -> FETCH.
//   - BRANCH:  alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00. -> FETCH.
// - Latency with zero wait states (cycles per instruction):
//   - R / I: 4.  lw: 5.  sw: 4.  beq: 3.  Illegal: 2.
// - Handshake:
//   - A request stays asserted, with a stable adr_src, until the edge where mem_ready=1.
//   - mem_ready is ignored in non-memory states.
// - Wait timer:
//   - Counts cycles in FETCH, MEM_RD and MEM_WR while !mem_ready; clears on any state change.
//   - Reaching WAIT_TIMEOUT without mem_ready: pulse bus_error, drop the request, -> FETCH.
//   - No PC, register or IR write occurs on a timeout.
//   - If mem_ready arrives in the same cycle the count hits WAIT_TIMEOUT, mem_ready wins: normal completion, no bus_error.
// - Reset mid-operation: all outputs drop to 0 immediately (asynchronous), even in the middle of a transaction.
// - Unused state encodings: treated as IDLE; -> FETCH on the next edge.
// STRUCTURE
// - Shared package riscv_ctrl_pkg:
//   - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH);
//   - ALU_OP_* codes;
//   - the state enum (4-bit);
//   - mux-select constants for alu_src_a, alu_src_b and result_src.
// - One sub-module, mc_wait_timer: counter with clr, en and expired outputs; width TMR_W; limit WAIT_TIMEOUT.
// - Top level: state register, next-state logic, and the output decode case statement.
// TESTING
// - Reset then R-type opcode 0110011, mem_ready=1 -> states IDLE,FETCH,DECODE,EXEC_R,ALU_WB; reg_write=1 only in ALU_WB; alu_op=10 in EXEC_R.
// - lw 0000011, mem_ready low 3 cycles in MEM_RD -> mem_read and adr_src=1 held 4 cycles; MEM_WB reg_write=1, result_src=01.
// - beq 1100011: zero=1 -> pc_write=1 in BRANCH; zero=0 -> pc_write=0; both return to FETCH.
// - opcode 1111111 -> illegal_op high exactly 1 cycle in DECODE; no reg_write, mem_write or pc_write; next state FETCH.
// - sw with mem_ready stuck low -> bus_error pulse after 16 cycles in MEM_WR; mem_write drops; -> FETCH.
// - Same sw case, mem_ready rises on cycle 16 -> no bus_error, normal completion.
// - rst_n asserted mid MEM_RD -> all outputs 0 same cycle; after release, IDLE then FETCH.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared opcodes, ALU/mux codes and state encoding for the multicycle controller
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    localparam logic [1:0] SRC_B_RS2    = 2'b00;
    localparam logic [1:0] SRC_B_IMM    = 2'b01;
    localparam logic [1:0] SRC_B_FOUR   = 2'b10;

    localparam logic [1:0] RES_ALU_REG  = 2'b00;
    localparam logic [1:0] RES_MEM_DATA = 2'b01;
    localparam logic [1:0] RES_ALU_OUT  = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEM_ADR = 4'd3,
        S_MEM_RD  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_MEM_WB  = 4'd6,
        S_EXEC_R  = 4'd7,
        S_EXEC_I  = 4'd8,
        S_ALU_WB  = 4'd9,
        S_BRANCH  = 4'd10
    } state_t;

endpackage

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - memory wait-state counter flagging the last permitted wait cycle
module mc_wait_timer #(
    parameter int WAIT_TIMEOUT = 16,
    parameter int TMR_W        = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TMR_W-1:0] LAST = TMR_W'(WAIT_TIMEOUT - 1);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // count holds the waits already seen, so this cycle is wait number WAIT_TIMEOUT
    assign expired = (count == LAST);

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle RISC-V sequencer driving datapath enables and mux selects
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 16,
    parameter int TMR_W        = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       illegal_op,
    output logic       bus_error,
    output logic       busy
);

    state_t state, state_next;
    logic   in_mem_wait;
    logic   tmr_expired;
    logic   timeout;

    assign in_mem_wait = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // mem_ready in the final wait cycle still completes the access
    assign timeout     = in_mem_wait && !mem_ready && tmr_expired;

    mc_wait_timer #(
        .WAIT_TIMEOUT(WAIT_TIMEOUT),
        .TMR_W       (TMR_W)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    ((state_next != state) || timeout),
        .en     (in_mem_wait && !mem_ready),
        .expired(tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_OP_ADD;
        result_src = RES_ALU_REG;
        illegal_op = 1'b0;
        bus_error  = timeout;
        busy       = 1'b1;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_FOUR;
                alu_op    = ALU_OP_ADD;
                if (mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_OP_ADD;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
                    OP_R:              state_next = S_EXEC_R;
                    OP_I:              state_next = S_EXEC_I;
                    OP_BRANCH:         state_next = S_BRANCH;
                    default: begin
                        illegal_op = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                state_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
                if (mem_ready)    state_next = S_MEM_WB;
                else if (timeout) state_next = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready || timeout) state_next = S_FETCH;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                result_src = RES_MEM_DATA;
                state_next = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                alu_op     = ALU_OP_FUNCT;
                state_next = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                alu_op     = ALU_OP_FUNCT;
                state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                result_src = RES_ALU_REG;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                alu_op     = ALU_OP_SUB;
                result_src = RES_ALU_REG;
                pc_write   = zero;
                state_next = S_FETCH;
            end
            default: begin
                // IDLE and unused encodings behave identically
                busy       = 1'b0;
                bus_error  = 1'b0;
                state_next = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - randomized self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BEQ    = 7'b1100011;
    localparam int         LIMIT  = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_read, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic       illegal_op, bus_error, busy;

    int errors = 0;
    int checks = 0;

    multicycle_control_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .adr_src   (adr_src),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .reg_write (reg_write),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .result_src(result_src),
        .illegal_op(illegal_op),
        .bus_error (bus_error),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    wire [16:0] obs = {mem_read, mem_write, adr_src, ir_write, pc_write, reg_write,
                       alu_src_a, alu_src_b, alu_op, result_src, illegal_op, bus_error, busy};

    // Expected control word for one cycle of a named instruction step
    function automatic logic [16:0] expect_step(input string ph, input logic rdy, input logic z,
                                                input logic to, input logic ill);
        logic mr = 0, mw = 0, as = 0, irw = 0, pcw = 0, rw = 0;
        logic [1:0] a = 0, b = 0, op = 0, rs = 0;
        if (ph == "FETCH") begin
            mr = 1; irw = rdy; pcw = rdy; b = 2'b10;
        end else if (ph == "DECODE") begin
            a = 2'b01; b = 2'b01;
        end else if (ph == "MEM_ADR") begin
            a = 2'b10; b = 2'b01;
        end else if (ph == "MEM_RD") begin
            mr = 1; as = 1;
        end else if (ph == "MEM_WR") begin
            mw = 1; as = 1;
        end else if (ph == "MEM_WB") begin
            rw = 1; rs = 2'b01;
        end else if (ph == "EXEC_R") begin
            a = 2'b10; op = 2'b10;
        end else if (ph == "EXEC_I") begin
            a = 2'b10; b = 2'b01; op = 2'b10;
        end else if (ph == "ALU_WB") begin
            rw = 1;
        end else if (ph == "BRANCH") begin
            a = 2'b10; op = 2'b01; pcw = z;
        end
        return {mr, mw, as, irw, pcw, rw, a, b, op, rs, ill, to, 1'b1};
    endfunction

    task automatic cyc(input logic rdy, input logic z, input logic [16:0] e, input string nm);
        mem_ready = rdy;
        zero      = z;
        @(negedge clk);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    // One memory access with w wait cycles; w >= LIMIT means the access never completes
    task automatic access(input string ph, input int w, output bit ok);
        logic z;
        ok = 1'b1;
        for (int i = 0; i < LIMIT; i++) begin
            z = 1'($urandom);
            if (i < w) begin
                if (i == LIMIT - 1) begin
                    cyc(1'b0, z, expect_step(ph, 1'b0, z, 1'b1, 1'b0), {ph, " timeout"});
                    ok = 1'b0;
                    return;
                end
                cyc(1'b0, z, expect_step(ph, 1'b0, z, 1'b0, 1'b0), {ph, " wait"});
            end else begin
                cyc(1'b1, z, expect_step(ph, 1'b1, z, 1'b0, 1'b0), {ph, " done"});
                return;
            end
        end
    endtask

    task automatic step(input string ph, input logic z, input logic ill);
        logic r = 1'($urandom);
        cyc(r, z, expect_step(ph, r, z, 1'b0, ill), ph);
    endtask

    task automatic run_instr(input logic [6:0] op, input logic z, input int fw, input int mw);
        bit ok;
        logic legal;
        opcode = op;
        access("FETCH", fw, ok);
        if (!ok) return;
        legal = (op == R_TYPE) || (op == I_TYPE) || (op == LW) || (op == SW) || (op == BEQ);
        step("DECODE", 1'($urandom), !legal);
        if (!legal) return;
        if (op == R_TYPE) begin
            step("EXEC_R", 1'($urandom), 1'b0);
            step("ALU_WB", 1'($urandom), 1'b0);
        end else if (op == I_TYPE) begin
            step("EXEC_I", 1'($urandom), 1'b0);
            step("ALU_WB", 1'($urandom), 1'b0);
        end else if (op == BEQ) begin
            step("BRANCH", z, 1'b0);
        end else if (op == LW) begin
            step("MEM_ADR", 1'($urandom), 1'b0);
            access("MEM_RD", mw, ok);
            if (ok) step("MEM_WB", 1'($urandom), 1'b0);
        end else begin
            step("MEM_ADR", 1'($urandom), 1'b0);
            access("MEM_WR", mw, ok);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'b1;
        opcode    = R_TYPE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== 17'h0) begin
            errors++;
            $display("FAIL reset outputs: got %h expected %h", obs, 17'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 1'b1, 17'h0, "IDLE after reset");
    endtask

    task automatic test_rtype();
        run_instr(R_TYPE, 1'b0, 0, 0);
        run_instr(I_TYPE, 1'b1, 2, 0);
    endtask

    task automatic test_lw_wait();
        run_instr(LW, 1'b0, 0, 3);
    endtask

    task automatic test_beq();
        run_instr(BEQ, 1'b1, 0, 0);
        run_instr(BEQ, 1'b0, 0, 0);
    endtask

    task automatic test_illegal();
        run_instr(7'b1111111, 1'b0, 0, 0);
    endtask

    task automatic test_sw_timeout();
        run_instr(SW, 1'b0, 0, LIMIT);
        run_instr(SW, 1'b0, 0, LIMIT - 1);
        run_instr(R_TYPE, 1'b0, LIMIT, 0);
    endtask

    task automatic test_reset_mid();
        bit ok;
        opcode = LW;
        access("FETCH", 0, ok);
        step("DECODE", 1'b0, 1'b0);
        step("MEM_ADR", 1'b0, 1'b0);
        cyc(1'b0, 1'b0, expect_step("MEM_RD", 1'b0, 1'b0, 1'b0, 1'b0), "MEM_RD before reset");
        mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 17'h0) begin
            errors++;
            $display("FAIL async reset mid MEM_RD: got %h expected %h", obs, 17'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 17'h0, "IDLE after mid reset");
    endtask

    task automatic test_random();
        logic [6:0] op;
        int         fw, mw, sel;
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: op = R_TYPE;
                1: op = I_TYPE;
                2: op = LW;
                3: op = SW;
                4: op = BEQ;
                default: op = 7'($urandom);
            endcase
            fw = ($urandom_range(0, 11) == 0) ? int'($urandom_range(LIMIT - 1, LIMIT + 1))
                                              : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 5) == 0)  ? int'($urandom_range(LIMIT - 1, LIMIT + 1))
                                              : int'($urandom_range(0, 4));
            run_instr(op, 1'($urandom), fw, mw);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_sw_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
